// File: rtl/dds_multi_core.sv
// Multi-channel direct digital synthesiser with per-channel waveform shaping and a
// round-robin DAC0832 write sequencer that streams one channel sample at a time.
module dds_multi_core #(
   parameter int NCH    = 2,
   parameter int ACC_W  = 24,
   parameter int FTW_W  = 16,
   parameter int OUT_W  = 8,
   parameter int WR_CYC = 2,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NCH*FTW_W-1:0]   ftw,
   input  logic [NCH*OUT_W-1:0]   phase_ofs,
   input  logic [NCH*2-1:0]       wave_sel,
   input  logic [NCH*OUT_W-1:0]   duty,
   input  logic [NCH-1:0]         sync,
   output logic [NCH*OUT_W-1:0]   wave_out,
   output logic [OUT_W-1:0]       dac_data,
   output logic [CH_W-1:0]        dac_ch,
   output logic                   DAC_ILE,
   output logic                   DAC_CS,
   output logic                   DAC_WR1,
   output logic                   DAC_WR2,
   output logic                   DAC_XFER
);

   localparam int CNT_W = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_WR   = 3'd2,
      S_GAP  = 3'd3,
      S_XFR  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   logic [ACC_W-1:0] acc_q  [NCH];
   logic [ACC_W-1:0] acc_d  [NCH];
   logic [OUT_W-1:0] wave_q [NCH];
   logic [OUT_W-1:0] wave_d [NCH];
   logic [OUT_W-1:0] phase_s;
   logic [OUT_W-1:0] tri_s;
   logic [OUT_W-1:0] sel_wave_s;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] dac_data_q, dac_data_d;
   logic [CH_W-1:0]  dac_ch_q, dac_ch_d;
   logic             ile_q;
   logic             cs_n_q, cs_n_d;
   logic             wr1_n_q, wr1_n_d;
   logic             wr2_n_q, wr2_n_d;
   logic             xfer_n_q, xfer_n_d;

   // Per-channel phase accumulation and waveform shaping from the registered phase
   always_comb begin
      phase_s = '0;
      tri_s   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sync[i]) begin
            acc_d[i] = '0;
         end else if (en) begin
            acc_d[i] = acc_q[i] + ACC_W'(ftw[i*FTW_W +: FTW_W]);
         end else begin
            acc_d[i] = acc_q[i];
         end
         phase_s = acc_q[i][ACC_W-1 -: OUT_W] + phase_ofs[i*OUT_W +: OUT_W];
         tri_s   = {phase_s[OUT_W-2:0], 1'b0};
         case (wave_sel[2*i +: 2])
            2'd0:    wave_d[i] = phase_s;
            2'd1:    wave_d[i] = phase_s[OUT_W-1] ? '0 : '1;
            2'd2:    wave_d[i] = phase_s[OUT_W-1] ? ~tri_s : tri_s;
            2'd3:    wave_d[i] = (phase_s < duty[i*OUT_W +: OUT_W]) ? '1 : '0;
            default: wave_d[i] = '0;
         endcase
      end
   end

   // Channel sample currently addressed by the DAC sequencer
   always_comb begin
      sel_wave_s = '0;
      for (int i = 0; i < NCH; i++) begin
         if (CH_W'(i) == dac_ch_q) begin
            sel_wave_s = wave_q[i];
         end else begin
            sel_wave_s = sel_wave_s;
         end
      end
   end

   // DAC sequencer next state; strobes are decoded from the next state so that the
   // registered strobes line up with the registered state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dac_data_d = dac_data_q;
      dac_ch_d   = dac_ch_q;
      cs_n_d     = 1'b1;
      wr1_n_d    = 1'b1;
      wr2_n_d    = 1'b1;
      xfer_n_d   = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            dac_data_d = sel_wave_s;
            cnt_d      = '0;
            state_d    = S_WR;
         end
         S_WR: begin
            if (cnt_q == CNT_W'(WR_CYC - 1)) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            cnt_d   = '0;
            state_d = S_XFR;
         end
         S_XFR: begin
            if (cnt_q == CNT_W'(WR_CYC - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (dac_ch_q == CH_W'(NCH - 1)) begin
               dac_ch_d = '0;
            end else begin
               dac_ch_d = dac_ch_q + 1'b1;
            end
            if (en) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      case (state_d)
         S_WR: begin
            cs_n_d  = 1'b0;
            wr1_n_d = 1'b0;
         end
         S_GAP: begin
            cs_n_d = 1'b0;
         end
         S_XFR: begin
            cs_n_d   = 1'b0;
            wr2_n_d  = 1'b0;
            xfer_n_d = 1'b0;
         end
         default: begin
            cs_n_d = 1'b1;
         end
      endcase
   end

   // State registers; reset aborts any DAC transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]  <= '0;
            wave_q[i] <= '0;
         end
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dac_data_q <= '0;
         dac_ch_q   <= '0;
         ile_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         wr1_n_q    <= 1'b1;
         wr2_n_q    <= 1'b1;
         xfer_n_q   <= 1'b1;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]  <= acc_d[i];
            wave_q[i] <= wave_d[i];
         end
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dac_data_q <= dac_data_d;
         dac_ch_q   <= dac_ch_d;
         ile_q      <= 1'b1;
         cs_n_q     <= cs_n_d;
         wr1_n_q    <= wr1_n_d;
         wr2_n_q    <= wr2_n_d;
         xfer_n_q   <= xfer_n_d;
      end
   end

   // Flatten registered samples onto the output bus
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         wave_out[i*OUT_W +: OUT_W] = wave_q[i];
      end
   end

   assign dac_data = dac_data_q;
   assign dac_ch   = dac_ch_q;
   assign DAC_ILE  = ile_q;
   assign DAC_CS   = cs_n_q;
   assign DAC_WR1  = wr1_n_q;
   assign DAC_WR2  = wr2_n_q;
   assign DAC_XFER = xfer_n_q;

endmodule

// File: tb/tb_dds_multi_core.sv
// Directed bench for dds_multi_core: default 2-channel instance plus a 16-bit
// single-channel instance for accumulator wrap behaviour.
module tb_dds_multi_core;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] ftw;
   logic [15:0] phase_ofs;
   logic [3:0]  wave_sel;
   logic [15:0] duty;
   logic [1:0]  sync;
   logic [15:0] wave_out;
   logic [7:0]  dac_data;
   logic [0:0]  dac_ch;
   logic        ile, cs_n, wr1_n, wr2_n, xfer_n;

   logic        en16;
   logic [15:0] wave16;
   logic [15:0] dac_data16;
   logic [0:0]  dac_ch16;
   logic        ile16, cs16, wr1_16, wr2_16, xfer16;

   int n_cmp;
   int n_fail;
   int n_en;

   dds_multi_core u_dut (
      .clk(clk), .rst(rst), .en(en), .ftw(ftw), .phase_ofs(phase_ofs),
      .wave_sel(wave_sel), .duty(duty), .sync(sync), .wave_out(wave_out),
      .dac_data(dac_data), .dac_ch(dac_ch), .DAC_ILE(ile), .DAC_CS(cs_n),
      .DAC_WR1(wr1_n), .DAC_WR2(wr2_n), .DAC_XFER(xfer_n)
   );

   dds_multi_core #(.NCH(1), .ACC_W(16), .FTW_W(16), .OUT_W(16), .WR_CYC(2)) u_dut16 (
      .clk(clk), .rst(rst), .en(en16), .ftw(16'hFFFF), .phase_ofs(16'h0000),
      .wave_sel(2'd0), .duty(16'h0000), .sync(1'b0), .wave_out(wave16),
      .dac_data(dac_data16), .dac_ch(dac_ch16), .DAC_ILE(ile16), .DAC_CS(cs16),
      .DAC_WR1(wr1_16), .DAC_WR2(wr2_16), .DAC_XFER(xfer16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         if (en) n_en++;
      end
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] strobes_for(input int j);
      logic c, w1, w2;
      c  = !(j >= 2 && j <= 6);
      w1 = !(j == 2 || j == 3);
      w2 = !(j == 5 || j == 6);
      return {1'b1, c, w1, w2, w2};
   endfunction

   initial begin
      logic [4:0] strb;
      int j;
      n_cmp = 0; n_fail = 0; n_en = 0;
      rst = 1'b1; en = 1'b0; en16 = 1'b0;
      ftw = 32'h0; phase_ofs = 16'h0; wave_sel = 4'h0; duty = 16'h0; sync = 2'b00;
      step(2);

      check("rst_wave",  {16'h0, wave_out}, 32'h0);
      check("rst_data",  {24'h0, dac_data}, 32'h0);
      check("rst_ch",    {31'h0, dac_ch},   32'h0);
      check("rst_strb",  {27'h0, ile, cs_n, wr1_n, wr2_n, xfer_n}, 32'h0F);

      // saw ramp: ch0 ftw 8000, ch1 ftw 4000
      rst = 1'b0; en = 1'b1; ftw = {16'h4000, 16'h8000};
      step(1);  check("saw_k1",   {24'h0, wave_out[7:0]}, 32'h00);
      step(3);  check("saw_k4",   {24'h0, wave_out[7:0]}, 32'h01);
      step(7);  check("saw_k11",  {24'h0, wave_out[7:0]}, 32'h05);
      check("saw1_k11", {24'h0, wave_out[15:8]}, 32'h02);
      step(501); check("saw_k512", {24'h0, wave_out[7:0]}, 32'hFF);
      step(1);  check("saw_wrap", {24'h0, wave_out[7:0]}, 32'h00);

      // sync has priority over en, only on channel 0
      sync = 2'b01; phase_ofs = 16'h0025;
      step(1);
      sync = 2'b00;
      step(1);
      check("sync_ch0", {24'h0, wave_out[7:0]},  32'h25);
      check("sync_ch1", {24'h0, wave_out[15:8]}, (n_en - 1) / 4 % 256);

      // static shaping tests with acc0 cleared and held
      en = 1'b0; ftw = 32'h0; sync = 2'b01;
      step(1);
      sync = 2'b00;
      wave_sel[1:0] = 2'd2; phase_ofs[7:0] = 8'h40; step(1); check("tri_40", {24'h0, wave_out[7:0]}, 32'h80);
      phase_ofs[7:0] = 8'hC0; step(1); check("tri_C0", {24'h0, wave_out[7:0]}, 32'h7F);
      phase_ofs[7:0] = 8'h7F; step(1); check("tri_7F", {24'h0, wave_out[7:0]}, 32'hFE);
      wave_sel[1:0] = 2'd1; step(1); check("sq_7F", {24'h0, wave_out[7:0]}, 32'hFF);
      phase_ofs[7:0] = 8'h80; step(1); check("sq_80", {24'h0, wave_out[7:0]}, 32'h00);
      wave_sel[1:0] = 2'd3; duty[7:0] = 8'h80; step(1); check("pul_80", {24'h0, wave_out[7:0]}, 32'h00);
      phase_ofs[7:0] = 8'h7F; step(1); check("pul_7F", {24'h0, wave_out[7:0]}, 32'hFF);
      wave_sel[1:0] = 2'd0; phase_ofs[7:0] = 8'h5A; step(1); check("saw_5A", {24'h0, wave_out[7:0]}, 32'h5A);

      // 16-bit accumulator with all-ones tuning word counts down without carry leakage
      en16 = 1'b1;
      step(1); check("w16_k1",  {16'h0, wave16}, 32'h0000);
      step(1); check("w16_k2",  {16'h0, wave16}, 32'hFFFF);
      step(1); check("w16_k3",  {16'h0, wave16}, 32'hFFFE);
      step(7); check("w16_k10", {16'h0, wave16}, 32'hFFF7);
      en16 = 1'b0;

      // DAC round robin with en held high
      rst = 1'b1; step(1);
      rst = 1'b0; ftw = 32'h0; wave_sel = 4'h0; phase_ofs = 16'h2211;
      en = 1'b1;
      step(1);
      for (int c = 0; c < 14; c++) begin
         j = c % 7 + 1;
         check($sformatf("strb_c%0d", c), {27'h0, ile, cs_n, wr1_n, wr2_n, xfer_n}, {27'h0, strobes_for(j)});
         check($sformatf("ch_c%0d", c), {31'h0, dac_ch}, (c / 7) % 2);
         if (j >= 2) begin
            check($sformatf("data_c%0d", c), {24'h0, dac_data}, ((c / 7) % 2 == 0) ? 32'h11 : 32'h22);
         end else begin
            check($sformatf("ile_c%0d", c), {31'h0, ile}, 32'h1);
         end
         step(1);
      end

      // en dropped during WR completes the channel then idles
      step(1);
      en = 1'b0;
      for (int k = 2; k <= 7; k++) begin
         check($sformatf("drop_j%0d", k), {27'h0, ile, cs_n, wr1_n, wr2_n, xfer_n}, {27'h0, strobes_for(k)});
         step(1);
      end
      check("drop_idle", {27'h0, ile, cs_n, wr1_n, wr2_n, xfer_n}, 32'h1F);
      check("drop_ch",   {31'h0, dac_ch}, 32'h1);
      step(3);
      check("idle_hold", {27'h0, ile, cs_n, wr1_n, wr2_n, xfer_n}, 32'h1F);
      check("idle_data", {24'h0, dac_data}, 32'h11);

      // reset during XFR aborts the transaction
      en = 1'b1;
      step(5);
      check("xfr_pre", {27'h0, ile, cs_n, wr1_n, wr2_n, xfer_n}, {27'h0, strobes_for(5)});
      rst = 1'b1;
      step(1);
      check("abort_strb", {27'h0, ile, cs_n, wr1_n, wr2_n, xfer_n}, 32'h0F);
      check("abort_ch",   {31'h0, dac_ch}, 32'h0);
      check("abort_data", {24'h0, dac_data}, 32'h0);
      rst = 1'b0; en = 1'b0;
      step(1);
      check("post_ile", {31'h0, ile}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
